nec_ir_tx: RTL and testbench
============================

// Module: nec_ir_tx
// PURPOSE
//  NEC-protocol infrared transmitter; the transmit end of the IR link whose receiver decodes
//  {address, command} frames. Serialises an 8-bit address/command pair into a NEC frame:
//  leader, 32 data bits, stop burst. Drives an IR LED with a 38 kHz carrier-modulated signal.
//  Sits beside the IR receiver path; start is issued by control logic (e.g. button/LED control).
// PARAMETERS
//  UNIT_CYC      28125  clock cycles per NEC time unit (562.5 us @ 50 MHz); must be >= 2
//  CARRIER_DIV   1316   carrier period in clock cycles (~38 kHz @ 50 MHz); must be >= 2
//  CARRIER_HIGH  438    carrier high cycles per period (~1/3 duty); 1 <= CARRIER_HIGH < CARRIER_DIV
// PORTS
//  clk_i        in   1  system clock
//  rst_i        in   1  synchronous reset, active-high
//  start_i      in   1  request frame; accepted only when busy_o=0
//  address_i    in   8  address byte, latched on accept
//  command_i    in   8  command byte, latched on accept
//  busy_o       out  1  high from cycle after accept until frame complete
//  done_o       out  1  one-cycle pulse, frame complete
//  envelope_o   out  1  unmodulated mark envelope (1 = mark)
//  ir_o         out  1  envelope_o AND carrier; drives IR LED, active-high
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0; reset mid-frame aborts immediately, no done_o.
//  - Accept: start_i=1 while busy_o=0 in cycle N -> address/command latched in cycle N;
//    busy_o=1 and envelope_o=1 from cycle N+1. start_i while busy_o=1 is ignored (not queued).
//  - Shift word = {~command, command, ~address, address}, transmitted bit 0 first (LSB first).
//  - FSM states / durations (in units of UNIT_CYC cycles):
//    IDLE -> LEADER (mark 16) -> LEADER_SPACE (space 8) -> BIT_MARK (mark 1)
//    -> BIT_SPACE (space 1 if bit=0, 3 if bit=1) -> BIT_MARK ... after the 32nd BIT_SPACE
//    -> STOP (mark 1) -> IDLE.
//  - Unit counter counts 0..UNIT_CYC-1; the state advances on the terminal count; bit index 0..31.
//  - Leaving STOP: next cycle done_o=1, busy_o=0, envelope_o=0. A start_i in that same cycle
//    is accepted (back-to-back frames allowed); inter-frame gap is the requester's responsibility.
//  - Frame length = (16+8+1 + sum over 32 bits of (2 or 4)) * UNIT_CYC cycles.
//  - Carrier counter 0..CARRIER_DIV-1: free-runs during marks and is reset to 0 on the first
//    cycle of every mark. carrier=1 when count < CARRIER_HIGH. Every burst therefore starts high.
//  - ir_o = envelope_o & carrier (registered); ir_o=0 during spaces and in IDLE.
//  - Inputs address_i/command_i may change freely after accept; the latched copy is used.
// TESTING  (bench params: UNIT_CYC=4, CARRIER_DIV=3, CARRIER_HIGH=1)
//  1 rst_i held 3 cycles, then released -> busy_o=done_o=envelope_o=ir_o=0; IDLE persists, no start.
//  2 start, addr=0x00 cmd=0x00 -> envelope high 64 cyc, low 32; 8x(4 hi,4 lo), 8x(4 hi,12 lo),
//    8x(4 hi,4 lo), 8x(4 hi,12 lo), 4 hi; total 484 cycles; done_o pulse once; ir_o=1,0,0 repeating in marks.
//  3 start, addr=0x5A cmd=0xC3 -> receiver-model decode of envelope_o gives addr 0x5A, ~addr 0xA5,
//    cmd 0xC3, ~cmd 0x3C (LSB first).
//  4 start pulsed again at cycle 100 of a frame -> ignored; frame identical to test 2; one done_o.
//  5 start held high continuously -> second frame begins the cycle after done_o, busy_o low 1 cycle.
//  6 rst_i asserted mid data bits -> next cycle all outputs 0, no done_o; new start gives full frame.

Source files
------------

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC infrared frame transmitter (leader, 32 LSB-first data bits, stop) with carrier-modulated LED drive
// Ports: clk_i/rst_i clock and sync active-high reset; start_i frame request (taken only when idle);
//        address_i/command_i bytes latched on accept; busy_o frame in progress; done_o one-cycle completion pulse;
//        envelope_o unmodulated mark envelope; ir_o envelope gated by carrier for the IR LED.
module nec_ir_tx #(
  parameter int UNIT_CYC = 28125,
  parameter int CARRIER_DIV = 1316,
  parameter int CARRIER_HIGH = 438
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] address_i,
  input  logic [7:0] command_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       envelope_o,
  output logic       ir_o
);
  localparam int UW = $clog2(UNIT_CYC);
  localparam int CW = $clog2(CARRIER_DIV);
  localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CARRIER_DIV - 1);
  localparam logic [CW-1:0] C_HIGH = CW'(CARRIER_HIGH);
  typedef enum logic [2:0] {IDLE, LEADER, LEADER_SPACE, BIT_MARK, BIT_SPACE, STOP} state_t;
  state_t state, state_n;
  logic [UW-1:0] ucnt;
  logic [3:0] ncnt, n_last;
  logic [4:0] bidx;
  logic [31:0] word;
  logic [CW-1:0] ccnt;
  logic done, unit_end, state_end, mark_n;
  // word[0] always holds the bit currently being sent; n_last is the state length in units minus one
  always_comb begin
    unit_end = ucnt == U_LAST;
    n_last = state == LEADER ? 4'd15 : state == LEADER_SPACE ? 4'd7 : (state == BIT_SPACE && word[0]) ? 4'd2 : 4'd0;
    state_end = unit_end && ncnt == n_last;
    state_n = state;
    case (state)
      IDLE:         state_n = start_i ? LEADER : IDLE;
      LEADER:       state_n = state_end ? LEADER_SPACE : LEADER;
      LEADER_SPACE: state_n = state_end ? BIT_MARK : LEADER_SPACE;
      BIT_MARK:     state_n = state_end ? BIT_SPACE : BIT_MARK;
      BIT_SPACE:    state_n = state_end ? (bidx == 5'd31 ? STOP : BIT_MARK) : BIT_SPACE;
      STOP:         state_n = state_end ? IDLE : STOP;
      default:      state_n = IDLE;
    endcase
    mark_n = state_n == LEADER || state_n == BIT_MARK || state_n == STOP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ucnt <= '0;
      ncnt <= '0;
      bidx <= '0;
      word <= '0;
      ccnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == STOP && state_end;
      // restarting on mark entry makes every burst begin with the carrier high
      ccnt <= (!mark_n || state_n != state || ccnt == C_LAST) ? '0 : ccnt + 1'b1;
      if (state == IDLE) begin
        if (start_i) word <= {~command_i, command_i, ~address_i, address_i};
      end else begin
        ucnt <= unit_end ? '0 : ucnt + 1'b1;
        ncnt <= state_end ? '0 : ncnt + 4'(unit_end);
        if (state == BIT_SPACE && state_end) begin
          word <= {1'b0, word[31:1]};
          bidx <= bidx + 1'b1;
        end
      end
    end
  end
  assign busy_o = state != IDLE;
  assign done_o = done;
  assign envelope_o = state == LEADER || state == BIT_MARK || state == STOP;
  assign ir_o = envelope_o && ccnt < C_HIGH;
endmodule

// File: tb/tb_nec_ir_tx.sv
// tb_nec_ir_tx: scoreboard bench for nec_ir_tx against a segment-level NEC frame model
module tb_nec_ir_tx;
  localparam int U = 4;
  localparam int CD = 3;
  localparam int CH = 1;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] addr = 0, cmd = 0;
  logic busy, done, env, ir;
  nec_ir_tx #(.UNIT_CYC(U), .CARRIER_DIV(CD), .CARRIER_HIGH(CH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .address_i(addr), .command_i(cmd),
    .busy_o(busy), .done_o(done), .envelope_o(env), .ir_o(ir));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] a; logic [7:0] c;} frame_t;
  frame_t exp_q[$];
  bit m_env[$], m_ir[$], cap_env[$], cap_ir[$];
  bit in_frame = 0;
  int checks = 0, failures = 0, cyc = 0, frames_done = 0, last_gap = -1, end_cyc = -1, last_len = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic void add_seg(input bit lvl, input int units);
    for (int k = 0; k < units * U; k++) begin
      m_env.push_back(lvl);
      m_ir.push_back(lvl && (k % CD) < CH);
    end
  endfunction
  function automatic void model(input frame_t f);
    logic [31:0] w;
    m_env.delete();
    m_ir.delete();
    w = {~f.c, f.c, ~f.a, f.a};
    add_seg(1, 16);
    add_seg(0, 8);
    for (int i = 0; i < 32; i++) begin
      add_seg(1, 1);
      add_seg(0, w[i] ? 3 : 1);
    end
    add_seg(1, 1);
  endfunction
  function automatic logic [31:0] decode();
    int runs[$];
    int n;
    bit cur;
    logic [31:0] w = 'x;
    if (cap_env.size() == 0 || cap_env[0] != 1) return w;
    cur = cap_env[0];
    n = 0;
    foreach (cap_env[i]) begin
      if (cap_env[i] == cur) n++;
      else begin
        runs.push_back(n);
        cur = cap_env[i];
        n = 1;
      end
    end
    runs.push_back(n);
    if (runs.size() < 67) return w;
    for (int i = 0; i < 32; i++) w[i] = runs[3 + 2 * i] > 2 * U;
    return w;
  endfunction
  task automatic check_frame();
    frame_t f;
    int em, im;
    logic [31:0] dw;
    last_len = cap_env.size();
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame actual_len=%0d required=none", last_len);
      return;
    end
    f = exp_q.pop_front();
    model(f);
    chk("frame_len", last_len, m_env.size());
    em = 0;
    im = 0;
    for (int i = 0; i < last_len && i < m_env.size(); i++) begin
      if (cap_env[i] != m_env[i]) em++;
      if (cap_ir[i] != m_ir[i]) im++;
    end
    chk("env_pattern_errs", em, 0);
    chk("ir_pattern_errs", im, 0);
    dw = decode();
    chk("dec_addr", {24'd0, dw[7:0]}, {24'd0, f.a});
    chk("dec_naddr", {24'd0, dw[15:8]}, {24'd0, ~f.a});
    chk("dec_cmd", {24'd0, dw[23:16]}, {24'd0, f.c});
    chk("dec_ncmd", {24'd0, dw[31:24]}, {24'd0, ~f.c});
    frames_done++;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      cap_env.delete();
      cap_ir.delete();
    end else begin
      if (busy && !in_frame) begin
        in_frame = 1;
        cap_env.delete();
        cap_ir.delete();
        if (end_cyc >= 0) last_gap = cyc - end_cyc;
      end
      if (in_frame && busy) begin
        cap_env.push_back(env);
        cap_ir.push_back(ir);
        if (done) chk("done_in_frame", done, 0);
      end else if (in_frame) begin
        in_frame = 0;
        end_cyc = cyc;
        chk("done_pulse", done, 1);
        check_frame();
      end else if (done || env || ir) begin
        chk("idle_outputs", {29'd0, done, env, ir}, 0);
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    addr = a;
    cmd = c;
    start = 1;
    exp_q.push_back('{a, c});
    @(negedge clk);
    start = 0;
    addr = 8'($urandom);
    cmd = 8'($urandom);
  endtask
  task automatic chk_zero(input string name);
    chk(name, {28'd0, busy, done, env, ir}, 0);
  endtask
  initial begin
    int fd, n;
    logic [7:0] a, c;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_zero("reset_outputs");
    repeat (10) @(negedge clk);
    chk_zero("idle_persist");
    send(8'h00, 8'h00);
    wait_idle();
    chk("t2_len", last_len, 484);
    chk("t2_frames", frames_done, 1);
    send(8'h5A, 8'hC3);
    wait_idle();
    chk("t3_frames", frames_done, 2);
    fd = frames_done;
    send(8'h00, 8'h00);
    repeat (98) @(negedge clk);
    addr = 8'hFF;
    cmd = 8'hFF;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("t4_frames", frames_done, fd + 1);
    chk("t4_len", last_len, 484);
    chk("t4_no_restart", {31'd0, busy}, 0);
    fd = frames_done;
    a = 8'($urandom);
    c = 8'($urandom);
    @(negedge clk);
    addr = a;
    cmd = c;
    start = 1;
    exp_q.push_back('{a, c});
    exp_q.push_back('{a, c});
    n = 0;
    while (frames_done < fd + 1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 0;
    wait_idle();
    chk("t5_frames", frames_done, fd + 2);
    chk("t5_gap", last_gap, 1);
    fd = frames_done;
    send(8'($urandom), 8'($urandom));
    repeat (200) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_zero("midreset_outputs");
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_zero("after_reset");
    chk("t6_no_done", frames_done, fd);
    send(8'($urandom), 8'($urandom));
    wait_idle();
    chk("t6_frames", frames_done, fd + 1);
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom));
      wait_idle();
    end
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
